multicycle_ctrl: RTL and testbench

Multi-cycle control unit for the single-processor core. It latches each instruction from instruction memory and decodes its opcode class. It then steps a FETCH/DECODE/EXEC/MEM/WB state machine that drives the steering and write-enable inputs of the fetch, regfile, execute and dmem blocks. The PC advances exactly once per instruction, and the unit counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Purpose:
//   Multi-cycle control unit for the single-processor core. It latches one
//   instruction per FETCH, classifies its opcode, and walks a
//   FETCH/DECODE/EXEC/MEM/WB sequence. Along the way it drives the steering
//   and strobe inputs of the fetch, regfile, execute and dmem blocks. The PC
//   is loaded exactly once per retired instruction (in WB), and retired
//   instructions are counted. An illegal opcode parks the unit in HALT until
//   reset.
//
// Ports:
//   i_clk          core clock, rising-edge active
//   i_rst          asynchronous active-high reset
//   i_instr[31:0]  instruction memory read data for the current pc
//   i_eq           execute-stage comparator (A == B), captured in EXEC
//   i_mem_ready    dmem access completes this cycle (looked at only in MEM)
//   o_pc_en        PC load strobe (WB only)
//   o_pc_sel[1:0]  00 pc+4, 01 jal/branch target, 10 jr target
//   o_addr_a/o_addr_b/o_write_addr[4:0]  IR[19:15] / IR[24:20] / IR[11:7]
//   o_imm[24:0]    IR[31:7]
//   o_imm_type     0 I-format, 1 S/B-format
//   o_op2_sel[1:0] 00 register B, 01 immediate, 10 shamt
//   o_alu_func[2:0] ALU function code
//   o_shft[1:0]    00 none, 01 sll, 10 srl, 11 sra
//   o_wb_sel[1:0]  00 ALU, 01 dmem read data, 10 pc+4
//   o_write        regfile write strobe (WB only)
//   o_write_en     dmem write strobe (MEM only)
//   o_halted       illegal opcode seen, core stopped
//   o_instret[31:0] retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter logic [31:0] RST_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_instr,
    input  logic        i_eq,
    input  logic        i_mem_ready,
    output logic        o_pc_en,
    output logic [1:0]  o_pc_sel,
    output logic [4:0]  o_addr_a,
    output logic [4:0]  o_addr_b,
    output logic [4:0]  o_write_addr,
    output logic [24:0] o_imm,
    output logic        o_imm_type,
    output logic [1:0]  o_op2_sel,
    output logic [2:0]  o_alu_func,
    output logic [1:0]  o_shft,
    output logic [1:0]  o_wb_sel,
    output logic        o_write,
    output logic        o_write_en,
    output logic        o_halted,
    output logic [31:0] o_instret
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    // Opcode class indices into w_cls.
    localparam int C_R     = 0;
    localparam int C_IALU  = 1;
    localparam int C_LOAD  = 2;
    localparam int C_STORE = 3;
    localparam int C_BEQ   = 4;
    localparam int C_JAL   = 5;
    localparam int C_JALR  = 6;
    localparam int N_CLS   = 7;

    // Opcode table, class C_R in the lowest 7 bits.
    localparam logic [N_CLS*7-1:0] OPC_LIST = {
        7'b1100111,   // JALR
        7'b1101111,   // JAL
        7'b1100011,   // BEQ
        7'b0100011,   // STORE
        7'b0000011,   // LOAD
        7'b0010011,   // I-ALU
        7'b0110011    // R
    };

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [31:0]      r_ir;
    logic             r_eq_q;
    logic [31:0]      r_instret;

    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic [4:0]       w_rd;
    logic [N_CLS-1:0] w_cls;
    logic             w_legal;
    logic             w_is_mem;
    logic             w_rd_writer;
    logic             w_active;

    assign w_opcode = r_ir[6:0];
    assign w_funct3 = r_ir[14:12];
    assign w_rd     = r_ir[11:7];

    // One-hot opcode class; an all-zero vector means illegal.
    genvar gi;
    generate
        for (gi = 0; gi < N_CLS; gi++) begin : g_cls
            assign w_cls[gi] = (w_opcode == OPC_LIST[gi*7 +: 7]);
        end
    endgenerate

    assign w_legal     = |w_cls;
    assign w_is_mem    = w_cls[C_LOAD] | w_cls[C_STORE];
    assign w_rd_writer = w_cls[C_R] | w_cls[C_IALU] | w_cls[C_LOAD]
                       | w_cls[C_JAL] | w_cls[C_JALR];

    // Steering is only meaningful once IR holds the instruction being run.
    assign w_active = (r_state == S_DECODE) || (r_state == S_EXEC)
                   || (r_state == S_MEM)    || (r_state == S_WB);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH:  w_state_next = S_DECODE;
            S_DECODE: w_state_next = w_legal ? S_EXEC : S_HALT;
            S_EXEC:   w_state_next = w_is_mem ? S_MEM : S_WB;
            S_MEM:    w_state_next = i_mem_ready ? S_WB : S_MEM;
            S_WB:     w_state_next = S_FETCH;
            S_HALT:   w_state_next = S_HALT;
            default:  w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_FETCH;
            r_ir      <= RST_INSTR;
            r_eq_q    <= 1'b0;
            r_instret <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_FETCH) begin
                r_ir <= i_instr;
            end
            if (r_state == S_EXEC) begin
                r_eq_q <= i_eq;
            end
            if (r_state == S_WB) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    // Register/immediate fields are passed straight through from IR.
    assign o_addr_a     = r_ir[19:15];
    assign o_addr_b     = r_ir[24:20];
    assign o_write_addr = w_rd;
    assign o_imm        = r_ir[31:7];

    // Strobes come purely from state, so an asynchronous reset kills them
    // at once.
    assign o_pc_en    = (r_state == S_WB);
    assign o_write    = (r_state == S_WB) && w_rd_writer && (w_rd != 5'd0);
    assign o_write_en = (r_state == S_MEM) && w_cls[C_STORE];
    assign o_halted   = (r_state == S_HALT);
    assign o_instret  = r_instret;

    always_comb begin
        o_op2_sel  = 2'b00;
        o_imm_type = 1'b0;
        o_alu_func = 3'b000;
        o_wb_sel   = 2'b00;
        o_shft     = 2'b00;
        o_pc_sel   = 2'b00;
        if (w_active) begin
            if (w_cls[C_R]) begin
                o_alu_func = w_funct3;
            end else if (w_cls[C_IALU]) begin
                // Immediate shifts take their operand from the shamt field.
                o_op2_sel  = ((w_funct3 == 3'b001) || (w_funct3 == 3'b101))
                           ? 2'b10 : 2'b01;
                o_alu_func = w_funct3;
            end else if (w_cls[C_LOAD]) begin
                o_op2_sel = 2'b01;
                o_wb_sel  = 2'b01;
            end else if (w_cls[C_STORE]) begin
                o_op2_sel  = 2'b01;
                o_imm_type = 1'b1;
            end else if (w_cls[C_BEQ]) begin
                o_imm_type = 1'b1;
            end else if (w_cls[C_JAL]) begin
                o_wb_sel = 2'b10;
            end else if (w_cls[C_JALR]) begin
                o_op2_sel = 2'b01;
                o_wb_sel  = 2'b10;
            end

            // Shift type is a pure funct3/IR[30] decode.
            case (w_funct3)
                3'b001:  o_shft = 2'b01;
                3'b101:  o_shft = r_ir[30] ? 2'b11 : 2'b10;
                default: o_shft = 2'b00;
            endcase

            // Next-PC choice only matters when the PC is actually loaded.
            if (r_state == S_WB) begin
                if (w_cls[C_BEQ]) begin
                    o_pc_sel = r_eq_q ? 2'b01 : 2'b00;
                end else if (w_cls[C_JAL]) begin
                    o_pc_sel = 2'b01;
                end else if (w_cls[C_JALR]) begin
                    o_pc_sel = 2'b10;
                end
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. Each issued instruction pushes a
// hand-computed expectation record into a scoreboard queue. A monitor pops
// the next record on every pc_en pulse and compares steering, latency and
// strobe counts. Reset, halt and abort behaviour are checked inline.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0000_0013;
    logic        eq = 1'b0;
    logic        mem_ready = 1'b0;

    logic        pc_en;
    logic [1:0]  pc_sel;
    logic [4:0]  addr_a, addr_b, write_addr;
    logic [24:0] imm;
    logic        imm_type;
    logic [1:0]  op2_sel;
    logic [2:0]  alu_func;
    logic [1:0]  shft;
    logic [1:0]  wb_sel;
    logic        write;
    logic        write_en;
    logic        halted;
    logic [31:0] instret;

    multicycle_ctrl #(.RST_INSTR(32'h0000_0013)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_instr      (instr),
        .i_eq         (eq),
        .i_mem_ready  (mem_ready),
        .o_pc_en      (pc_en),
        .o_pc_sel     (pc_sel),
        .o_addr_a     (addr_a),
        .o_addr_b     (addr_b),
        .o_write_addr (write_addr),
        .o_imm        (imm),
        .o_imm_type   (imm_type),
        .o_op2_sel    (op2_sel),
        .o_alu_func   (alu_func),
        .o_shft       (shft),
        .o_wb_sel     (wb_sel),
        .o_write      (write),
        .o_write_en   (write_en),
        .o_halted     (halted),
        .o_instret    (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          cycles;
        int          n_write;
        int          n_we;
        logic [4:0]  waddr;
        logic [1:0]  wb_sel;
        logic [1:0]  pc_sel;
        logic [1:0]  op2_sel;
        logic        imm_type;
        logic [2:0]  alu;
        logic [1:0]  shft;
        logic [31:0] instret;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_instret = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one instruction aligned to its FETCH cycle. n_wait is the number
    // of mem_ready=0 cycles in MEM (meaningful only for load/store).
    task automatic run_instr(input string name, input logic [31:0] ins, input logic eq_v,
                             input int n_wait, input bit is_mem, input bit wr, input bit we,
                             input logic [4:0] waddr, input logic [1:0] wbs,
                             input logic [1:0] pcs, input logic [1:0] op2,
                             input logic it, input logic [2:0] alu, input logic [1:0] sh);
        exp_t e;
        int   total;
        total      = is_mem ? (5 + n_wait) : 4;
        e.name     = name;
        e.cycles   = total;
        e.n_write  = wr ? 1 : 0;
        e.n_we     = we ? 1 : 0;
        e.waddr    = waddr;
        e.wb_sel   = wbs;
        e.pc_sel   = pcs;
        e.op2_sel  = op2;
        e.imm_type = it;
        e.alu      = alu;
        e.shft     = sh;
        e.instret  = exp_instret;
        sb.push_back(e);
        exp_instret = exp_instret + 32'd1;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            if (k == 1) begin
                instr = ins;
                eq    = eq_v;
                // Steering must be quiet in FETCH whatever IR still holds.
                chk({name, "_fetch_wb_sel"}, {30'd0, wb_sel}, 32'd0);
                chk({name, "_fetch_op2_sel"}, {30'd0, op2_sel}, 32'd0);
            end
            if (k == 2) begin
                chk({name, "_addr_a"}, {27'd0, addr_a}, {27'd0, ins[19:15]});
                chk({name, "_addr_b"}, {27'd0, addr_b}, {27'd0, ins[24:20]});
                chk({name, "_imm"}, {7'd0, imm}, {7'd0, ins[31:7]});
            end
            mem_ready = (k >= 4 + n_wait);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        exp_instret = 32'd0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        fork
            // Monitor: per-instruction counters, popped on every pc_en.
            begin
                int   cnt;
                int   wr_cnt;
                int   we_cnt;
                exp_t e;
                cnt = 0; wr_cnt = 0; we_cnt = 0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        cnt = 0; wr_cnt = 0; we_cnt = 0;
                    end else begin
                        cnt++;
                        if (write)    wr_cnt++;
                        if (write_en) we_cnt++;
                        if (pc_en) begin
                            if (sb.size() == 0) begin
                                chk("pc_en_unexpected", {31'd0, pc_en}, 32'd0);
                            end else begin
                                e = sb.pop_front();
                                chk({e.name, "_cycles"}, cnt, e.cycles);
                                chk({e.name, "_write_cnt"}, wr_cnt, e.n_write);
                                chk({e.name, "_write_en_cnt"}, we_cnt, e.n_we);
                                chk({e.name, "_write_addr"}, {27'd0, write_addr}, {27'd0, e.waddr});
                                chk({e.name, "_wb_sel"}, {30'd0, wb_sel}, {30'd0, e.wb_sel});
                                chk({e.name, "_pc_sel"}, {30'd0, pc_sel}, {30'd0, e.pc_sel});
                                chk({e.name, "_op2_sel"}, {30'd0, op2_sel}, {30'd0, e.op2_sel});
                                chk({e.name, "_imm_type"}, {31'd0, imm_type}, {31'd0, e.imm_type});
                                chk({e.name, "_alu_func"}, {29'd0, alu_func}, {29'd0, e.alu});
                                chk({e.name, "_shft"}, {30'd0, shft}, {30'd0, e.shft});
                                chk({e.name, "_instret"}, instret, e.instret);
                            end
                            cnt = 0; wr_cnt = 0; we_cnt = 0;
                        end
                    end
                end
            end
            // Stimulus
            begin
                int pc_cnt;
                // Reset state, sampled while rst is still high.
                @(negedge clk);
                chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
                chk("rst_write", {31'd0, write}, 32'd0);
                chk("rst_write_en", {31'd0, write_en}, 32'd0);
                chk("rst_halted", {31'd0, halted}, 32'd0);
                chk("rst_instret", instret, 32'd0);
                chk("rst_steer", {24'd0, op2_sel, wb_sel, pc_sel, shft}, 32'd0);
                chk("rst_imm", {7'd0, imm}, 32'd0);
                @(posedge clk);
                #2 rst = 1'b0;

                //        name    instr         eq  wait mem wr we waddr wb     pc     op2    it    alu     shft
                run_instr("add",  32'h002081B3, 0, 0, 0, 1, 0, 5'd3, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 2'b00);
                run_instr("lw",   32'h0080A283, 0, 2, 1, 1, 0, 5'd5, 2'b01, 2'b00, 2'b01, 1'b0, 3'b000, 2'b00);
                run_instr("sw",   32'h0020A223, 0, 0, 1, 0, 1, 5'd4, 2'b00, 2'b00, 2'b01, 1'b1, 3'b000, 2'b00);
                run_instr("beq1", 32'h00208463, 1, 0, 0, 0, 0, 5'd8, 2'b00, 2'b01, 2'b00, 1'b1, 3'b000, 2'b00);
                run_instr("beq0", 32'h00208463, 0, 0, 0, 0, 0, 5'd8, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 2'b00);
                run_instr("addi0",32'h00500013, 0, 0, 0, 0, 0, 5'd0, 2'b00, 2'b00, 2'b01, 1'b0, 3'b000, 2'b00);
                run_instr("jalr", 32'h000100E7, 0, 0, 0, 1, 0, 5'd1, 2'b10, 2'b10, 2'b01, 1'b0, 3'b000, 2'b00);
                run_instr("jal",  32'h008000EF, 0, 0, 0, 1, 0, 5'd1, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 2'b00);
                run_instr("srai", 32'h4032D213, 0, 0, 0, 1, 0, 5'd4, 2'b00, 2'b00, 2'b10, 1'b0, 3'b101, 2'b11);
                run_instr("slli", 32'h00131313, 0, 0, 0, 1, 0, 5'd6, 2'b00, 2'b00, 2'b10, 1'b0, 3'b001, 2'b01);
                run_instr("sra",  32'h409453B3, 0, 0, 0, 1, 0, 5'd7, 2'b00, 2'b00, 2'b00, 1'b0, 3'b101, 2'b11);

                // Illegal opcode: FETCH, DECODE, then HALT for good.
                @(negedge clk);
                instr = 32'hFFFF_FFFF;
                @(negedge clk);
                chk("ill_decode_halted", {31'd0, halted}, 32'd0);
                @(negedge clk);
                chk("ill_halted", {31'd0, halted}, 32'd1);
                pc_cnt = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (pc_en) pc_cnt++;
                end
                chk("ill_pc_en_cnt", pc_cnt, 32'd0);
                chk("ill_halted_hold", {31'd0, halted}, 32'd1);
                chk("ill_instret", instret, exp_instret);
                #2 rst = 1'b1;
                #1 chk("ill_rst_halted", {31'd0, halted}, 32'd0);
                exp_instret = 32'd0;
                @(posedge clk);
                @(posedge clk);
                #2 rst = 1'b0;

                // Reset aborting a store stuck in MEM.
                run_instr("add_b", 32'h002081B3, 0, 0, 0, 1, 0, 5'd3, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 2'b00);
                for (int k = 1; k <= 5; k++) begin
                    @(negedge clk);
                    if (k == 1) instr = 32'h0020A223;
                    mem_ready = 1'b0;
                end
                chk("abort_we_before", {31'd0, write_en}, 32'd1);
                chk("abort_instret_before", instret, exp_instret);
                #2 rst = 1'b1;
                #1;
                chk("abort_we_after", {31'd0, write_en}, 32'd0);
                chk("abort_pc_en_after", {31'd0, pc_en}, 32'd0);
                chk("abort_halted_after", {31'd0, halted}, 32'd0);
                chk("abort_instret_after", instret, 32'd0);
                exp_instret = 32'd0;
                @(posedge clk);
                @(posedge clk);
                #2 rst = 1'b0;
                run_instr("add_c", 32'h002081B3, 0, 0, 0, 1, 0, 5'd3, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 2'b00);
                @(negedge clk);
                chk("final_instret", instret, 32'd1);
                chk("sb_pending", sb.size(), 32'd0);
                if (0) do_reset();
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
